// File: rtl/pc_fetch.sv
// PC register and instruction-fetch sequencer: req/ack fetch into a small decode FIFO, flushed on redirect.
// Optional misaligned-PC trap (fetch_err + HALT) enabled by defining PCF_ALIGN_CHECK_EN.
module pc_fetch #(
  parameter logic [7:0] RESET_PC   = 8'h00,
  parameter int         FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  address_in,
  input  logic        redirect,
  input  logic        stall,
  output logic [7:0]  pc_out,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [7:0]  instr_pc,
  input  logic        instr_ready
`ifdef PCF_ALIGN_CHECK_EN
  ,
  output logic        fetch_err
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
`ifdef PCF_ALIGN_CHECK_EN
    ,
    S_HALT
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         pc_q, pc_d;
  logic               req_q, req_d;
  logic [7:0]         addr_q, addr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        data_q [FIFO_DEPTH];
  logic [7:0]         tag_q  [FIFO_DEPTH];
  logic               push, pop, flush, launch_ok, pc_load;
`ifdef PCF_ALIGN_CHECK_EN
  logic               err_q, err_d;
`endif

  always_comb begin
    pop  = (count_q != '0) && instr_ready;
    push = (state_q == S_FETCH) && req_q && imem_ack && !redirect;
`ifdef PCF_ALIGN_CHECK_EN
    flush = redirect && (state_q != S_HALT);
`else
    flush = redirect;
`endif

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Realign the read pointer so the next push lands at the head.
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Using the post-update count guarantees a launched request always has a free slot.
    launch_ok = !stall && (count_d < CNT_W'(FIFO_DEPTH));

    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    pc_load = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (redirect) begin
          pc_d    = address_in;
          pc_load = 1'b1;
        end
        req_d = launch_ok;
        if (launch_ok) addr_d = pc_d;
      end
      S_FETCH: begin
        if (req_q && !imem_ack) begin
          if (redirect) begin
            pc_d    = address_in;
            pc_load = 1'b1;
            state_d = S_DRAIN;
          end
        end else begin
          if (redirect || req_q) begin
            pc_d    = address_in;
            pc_load = 1'b1;
          end
          req_d = launch_ok;
          if (launch_ok) addr_d = pc_d;
        end
      end
      S_DRAIN: begin
        if (redirect) begin
          pc_d    = address_in;
          pc_load = 1'b1;
        end
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
`ifdef PCF_ALIGN_CHECK_EN
      S_HALT: begin
        if (imem_ack) req_d = 1'b0;
      end
`endif
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase

`ifdef PCF_ALIGN_CHECK_EN
    err_d = err_q;
    if (pc_load && (address_in[1:0] != 2'b00)) begin
      err_d   = 1'b1;
      state_d = S_HALT;
      req_d   = req_q && !imem_ack;
      addr_d  = addr_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef PCF_ALIGN_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef PCF_ALIGN_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= 32'h0;
        tag_q[i]  <= 8'h00;
      end
    end else if (push) begin
      data_q[wr_ptr_q] <= imem_rdata;
      tag_q[wr_ptr_q]  <= addr_q;
    end
  end

  assign pc_out      = pc_q;
  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = (count_q != '0);
  assign instr       = data_q[rd_ptr_q];
  assign instr_pc    = tag_q[rd_ptr_q];
`ifdef PCF_ALIGN_CHECK_EN
  assign fetch_err   = err_q;
`endif

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter register and instruction-fetch sequencer for the 8-bit-address core. It holds the current PC and drives it to the next-address adder's `address` input. It loads the adder's `address_out` back as the next PC and fetches 32-bit instructions from instruction memory over a req/ack handshake. Fetched words are buffered in a small FIFO for decode, and the FIFO is flushed on a taken-branch redirect.

## Interface
- `RESET_PC`, default 8'h00: PC value loaded on reset.
- `FIFO_DEPTH`, default 2: instruction buffer entries, a power of two ≥ 2.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `address_in` input, 8 bits: next PC from the adder's `address_out` (PC+4 or branch target).
- `redirect` input, 1 bit: taken branch (the adder's PCsrc); `address_in` holds the target.
- `stall` input, 1 bit: when high, no new fetch is launched.
- `pc_out` output, 8 bits: current PC, feeds the adder's `address`.
- `imem_req` output, 1 bit: fetch request.
- `imem_addr` output, 8 bits: fetch address, stable while `imem_req` is high.
- `imem_ack` input, 1 bit: memory response valid; `imem_rdata` is valid in the same cycle.
- `imem_rdata` input, 32 bits: fetched instruction.
- `instr_valid` output, 1 bit: FIFO head is valid.
- `instr` output, 32 bits: FIFO head instruction.
- `instr_pc` output, 8 bits: PC of the FIFO head.
- `instr_ready` input, 1 bit: decode accepts the head; a pop occurs when `instr_valid & instr_ready`.
- `fetch_err` output, 1 bit: misaligned-PC error, sticky. Present only with `PCF_ALIGN_CHECK_EN`.

## Operation
- State machine states: IDLE, FETCH, DRAIN, and HALT (HALT exists only with the macro).
- IDLE: the state on reset exit. Moves to FETCH unconditionally after one cycle.
- FETCH, launching a request: `imem_req` rises with `imem_addr <= pc_out` when all of the following hold:
  - no request is outstanding;
  - `stall` is low;
  - FIFO count < `FIFO_DEPTH`.
- FETCH, holding a request: once `imem_req` is high, it stays high with a stable `imem_addr` until `imem_ack`, regardless of `stall`, FIFO state or `redirect`.
- FETCH, on `imem_ack` without `redirect`:
  - push {`imem_addr`, `imem_rdata`} into the FIFO;
  - `pc_out <= address_in`;
  - drop `imem_req` for one cycle at most; back-to-back requests are allowed from the next cycle.
- `redirect` handling, any state except HALT:
  - `pc_out <= address_in`;
  - FIFO count <= 0, and `instr_valid` falls next cycle;
  - if a request is outstanding and not acked this cycle, move to DRAIN.
- DRAIN: keep `imem_req` on the old address until `imem_ack`. Discard that data, with no push and no PC update, then return to FETCH.
- Redirect inside DRAIN: update `pc_out` only and stay in DRAIN.
- FIFO: a circular buffer with separate read and write pointers that wrap modulo `FIFO_DEPTH`. A push and a pop in the same cycle on a full FIFO are both legal.
- Widths: all PC and address values are 8 bits. No arithmetic is done here; the increment lives in the adder.

## Timing
- Reset values:
  - `pc_out = RESET_PC`;
  - `imem_req = 0` and `imem_addr = 0`;
  - `instr_valid = 0`, `instr = 0` and `instr_pc = 0`;
  - `fetch_err = 0`;
  - FIFO empty, state IDLE.
- Reset asserted mid-transaction aborts immediately. The memory must tolerate a `req` that drops without an ack.
- Latency:
  - first `imem_req` appears 1 cycle after reset release (the IDLE cycle);
  - `instr_valid` rises 1 cycle after the `imem_ack` edge.
- Throughput: with a zero-wait memory (ack in the same cycle as req) and `instr_ready` held high, one instruction per cycle.
- Simultaneous `redirect` and `imem_ack`: the ack data is discarded and `pc_out <= address_in`. No DRAIN is needed.
- Simultaneous `redirect` and pop: the flush wins.
- Simultaneous `redirect` and `stall`: the redirect still takes effect.
- Full FIFO with `instr_ready` low: no new request is launched. A held request completes and its push is guaranteed space, because a launch requires count < `FIFO_DEPTH` and count only decreases while the request is pending.

## Configuration
- Macro `PCF_ALIGN_CHECK_EN`.
- Defined:
  - on any PC load (on ack or on redirect) with `address_in[1:0] != 2'b00`, `pc_out` still loads;
  - `fetch_err` sets and stays set until reset;
  - the state goes to HALT: no further requests, though an outstanding request still completes and its data is discarded;
  - `redirect` is ignored while in HALT.
- Undefined: no `fetch_err` port, no HALT state, and misaligned addresses are fetched as given.

## Test plan
- Reset release with zero-wait memory, `address_in = pc_out + 4`, `instr_ready = 1`: `imem_addr` sequence is 00, 04, 08, 0C, with `instr_pc` trailing by 1 cycle.
- `instr_ready = 0` with `FIFO_DEPTH = 2`: exactly 2 fetches, then `imem_req` stays low. Raising `instr_ready` pops 00 then 04 and resumes fetching at 08.
- `imem_ack` delayed 3 cycles with `stall` pulsed during the wait: `imem_req` and `imem_addr` stay stable throughout, and a single push occurs.
- `redirect` with `address_in = 8'h40` while the request for 0C is outstanding: the FIFO empties, DRAIN discards the 0C data, and the next `imem_addr` is 40.
- `redirect` in the same cycle as `imem_ack`: no push, and the next request is at the target.
- Macro defined with `address_in = 8'h06`: `fetch_err = 1` and no further `imem_req` until `rst_n` is pulsed low.
